// File: rtl/ifm_stream_feeder.sv
// ifm_stream_feeder: row-edge feeder producing a bit-reversed rate-coded ifm stream for the PE array
module ifm_stream_feeder #(
    parameter int IWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] in_ifm,
    input  logic [IWIDTH:0]   in_len,
    input  logic              out_ready,
    output logic              busy,
    output logic              ifm_dff,
    output logic              en_i,
    output logic              clr_i,
    output logic              en_o,
    output logic              clr_o,
    output logic              mac_done
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    localparam logic [IWIDTH:0] FULL = {1'b1, {IWIDTH{1'b0}}};

    state_t              state, next;
    logic [IWIDTH:0]     cnt, len_q, len_c;
    logic [IWIDTH-1:0]   ifm_q, rev;

    for (genvar i = 0; i < IWIDTH; i++) begin : g_rev
        assign rev[i] = cnt[IWIDTH-1-i];
    end

    // next-state decode and clamp of the requested stream length
    always_comb begin
        next  = state;
        len_c = (in_len == '0 || in_len > FULL) ? FULL : in_len;
        case (state)
            IDLE:    next = in_valid ? CLR : IDLE;
            CLR:     next = RUN;
            RUN:     next = (cnt == len_q - 1'b1) ? DONE : RUN;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    // state, datapath and registered outputs; PE controls lag the state by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ifm_q    <= '0;
            len_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            ifm_dff  <= 1'b0;
            en_i     <= 1'b0;
            en_o     <= 1'b0;
            clr_i    <= 1'b0;
            clr_o    <= 1'b0;
            mac_done <= 1'b0;
        end else begin
            state    <= next;
            in_ready <= next == IDLE;
            busy     <= next != IDLE;
            if (state == IDLE && in_valid) begin
                ifm_q <= in_ifm;
                len_q <= len_c;
            end
            cnt      <= state == CLR ? '0 : state == RUN ? cnt + 1'b1 : cnt;
            clr_i    <= state == CLR;
            clr_o    <= state == CLR;
            en_i     <= state == RUN;
            en_o     <= state == RUN;
            ifm_dff  <= state == RUN && ifm_q > rev;
            mac_done <= state == DONE;
        end
    end
endmodule
